tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receive end of the team's time-division multiplexed sample link; the counterpart to the mux-based TDM transmitter.
- Accepts one W-bit sample per valid cycle on a single shared bus, framed by a start-of-frame marker.
- Steers each slot to its channel register and publishes all N channels atomically once the frame completes.
- Sits between the lab-board serial sample source and the per-channel display/processing logic.

Parameters:
- W, 8, sample width in bits (≥1)
- N, 4, channels per frame (≥2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  W  slot sample
- din_valid  input  1  din holds a slot this cycle
- sof  input  1  qualifies din as slot 0; ignored when din_valid=0
- ch_data  output  N*W  published channels; channel k at bits [k*W +: W]
- frame_valid  output  1  one-cycle pulse: ch_data just updated
- frame_err  output  1  one-cycle pulse: frame discarded
- in_frame  output  1  high while in RECV

Behaviour:
- Reset is asserted asynchronously and released synchronously with clk. On reset: ch_data=0, frame_valid=0, frame_err=0, in_frame=0, shadow registers=0, slot counter=0, state=HUNT. Reset mid-frame discards the partial frame silently; no frame_err.
- Accepted slot = rising edge with din_valid=1. Cycles with din_valid=0 change nothing except frame_valid/frame_err, which clear. Gaps of any length are legal.
- FSM HUNT:
  - Accepted slot with sof=1: shadow[0]<=din, slot<=1, go to RECV.
  - Accepted slot with sof=0: discard, stay in HUNT, no error.
- FSM RECV, accepted slot with sof=0:
  - Store shadow[slot]<=din and increment slot.
  - If this is the final slot (slot index N-1, or index N when the optional feature is enabled): on the same edge copy shadow to ch_data. The final slot's own data goes directly into ch_data. Set frame_valid=1 for the next cycle, return to HUNT, slot<=0.
- FSM RECV, accepted slot with sof=1 (early sof): frame_err=1 for one cycle and the partial frame is dropped. ch_data is unchanged. This sample starts a new frame: shadow[0]<=din, slot<=1, stay in RECV.
- Latency: frame_valid and new ch_data are visible in the cycle after the edge that accepts the final slot.
- Back-to-back frames with sof immediately after the final slot are accepted with no dead cycle.
- frame_valid and frame_err are never both 1.
- ch_data holds its value between frames.
- in_frame = (state==RECV).
- Slot counter width is clog2(N+1) and never exceeds the final index.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - Each frame carries an extra slot N (after channel N-1) holding the XOR of the N data words.
  - The frame is complete on slot N.
  - On match: update ch_data and pulse frame_valid.
  - On mismatch: frame_err pulse, ch_data unchanged, return to HUNT.
  - An early sof during the parity slot follows the early-sof rule.
- Not defined:
  - Frames are exactly N slots. No parity logic or storage is built.

Test Plan (W=8, N=4, feature off unless stated):
- Reset then frame 0x11,0x22,0x33,0x44 (sof on first), all consecutive -> one cycle after the 4th edge: ch_data=0x44332211, frame_valid high exactly 1 cycle.
- Same frame with din_valid low for 3 cycles between slots 1 and 2 -> identical ch_data, single frame_valid; in_frame high throughout the gap.
- Samples 0xAA,0xBB with sof=0 while in HUNT, then valid frame 1,2,3,4 -> leading samples ignored, ch_data=0x04030201, no frame_err.
- Slots 0x01,0x02 then sof with 0x10, then 0x20,0x30,0x40 -> frame_err pulse on the early-sof edge. ch_data keeps its previous value until it updates to 0x40302010 with frame_valid.
- rst_n driven low mid-frame between clock edges -> outputs zero immediately, no pulses. The following full frame decodes correctly.
- TDM_PARITY_EN: frame 0x01,0x02,0x04,0x08,parity 0x0F -> ch_data=0x08040201, frame_valid. Repeat with parity 0x0E -> frame_err, ch_data unchanged.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of the TDM sample link.
//
// Accepts one W-bit slot per cycle in which din_valid is high. A slot with sof high starts a
// frame. Slots are steered into shadow registers, and all N channels are published to ch_data
// together once the final slot of the frame has been accepted.
//
// Optional feature (macro TDM_PARITY_EN): each frame carries one extra slot after channel N-1.
// That slot holds the XOR of the N data words. A frame is published only if this parity matches;
// on a mismatch the frame is discarded and frame_err pulses. Without the macro, frames are
// exactly N slots and no parity logic is built.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   din          slot sample
//   din_valid    din holds a slot this cycle
//   sof          marks din as slot 0 (only meaningful with din_valid)
//   ch_data      published channels, channel k at bits [k*W +: W]
//   frame_valid  one-cycle pulse: ch_data was just updated
//   frame_err    one-cycle pulse: a frame was discarded
//   in_frame     high while a frame is being received
module tdm_demux #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sof,
  output logic [N*W-1:0] ch_data,
  output logic           frame_valid,
  output logic           frame_err,
  output logic           in_frame
);

  localparam int unsigned SW = $clog2(N + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
`ifdef TDM_PARITY_EN
  localparam int unsigned LastIdx = N;
`else
  localparam int unsigned LastIdx = N - 1;
`endif
  localparam logic [SW-1:0] LastSlot = SW'(LastIdx);

  typedef enum logic [0:0] {StHunt, StRecv} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [N-1:0][W-1:0]  shadow_q, shadow_d;
  logic [N*W-1:0]       ch_data_q, ch_data_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [N-1:0][W-1:0]  frame_words;
  logic [IW-1:0]        slot_idx;

  // Non-final slots always have an index below N, so the narrow index is exact where used.
  assign slot_idx = slot_q[IW-1:0];

`ifdef TDM_PARITY_EN
  logic [W-1:0] parity;

  always_comb begin
    parity = '0;
    for (int k = 0; k < int'(N); k++) begin
      parity = parity ^ shadow_q[k];
    end
  end

  // All data words are already in the shadow when the parity slot arrives.
  assign frame_words = shadow_q;
`else
  // The final data slot bypasses the shadow and lands in ch_data on the same edge.
  always_comb begin
    frame_words        = shadow_q;
    frame_words[N-1]   = din;
  end
`endif

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (sof) begin
            shadow_d[0] = din;
            slot_d      = SW'(1);
            state_d     = StRecv;
          end
        end
        StRecv: begin
          if (sof) begin
            // Early sof: drop the partial frame and restart from this sample.
            frame_err_d = 1'b1;
            shadow_d[0] = din;
            slot_d      = SW'(1);
          end else if (slot_q == LastSlot) begin
            state_d = StHunt;
            slot_d  = '0;
`ifdef TDM_PARITY_EN
            if (din == parity) begin
              ch_data_d     = frame_words;
              frame_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
`else
            shadow_d[N-1] = din;
            ch_data_d     = frame_words;
            frame_valid_d = 1'b1;
`endif
          end else begin
            shadow_d[slot_idx] = din;
            slot_d             = slot_q + SW'(1);
          end
        end
        default: begin
          state_d = StHunt;
          slot_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      slot_q        <= '0;
      shadow_q      <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign in_frame    = (state_q == StRecv);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (W=8, N=4). A small behavioural model of the link pushes the
// expected frame outcome (publish or discard, with the ch_data value expected afterwards) onto a
// scoreboard as slots are driven; a negedge monitor pops and compares on every output pulse.
module tb_tdm_demux;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;
`ifdef TDM_PARITY_EN
  localparam int FLen = N + 1;
`else
  localparam int FLen = N;
`endif

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           sof;
  logic [N*W-1:0] ch_data;
  logic           frame_valid;
  logic           frame_err;
  logic           in_frame;

  tdm_demux #(
    .W(W),
    .N(N)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .ch_data    (ch_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .in_frame   (in_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic           is_err;
    logic [N*W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Model state
  bit             m_recv = 1'b0;
  int             m_n = 0;
  logic [W-1:0]   m_buf[0:N];
  logic [N*W-1:0] m_ch = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [N*W-1:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    sb.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] d, input logic s);
    logic         ok;
    logic [W-1:0] par;
    @(negedge clk);
    din       = d;
    sof       = s;
    din_valid = 1'b1;
    @(posedge clk);
    if (!m_recv) begin
      if (s) begin
        m_recv    = 1'b1;
        m_buf[0]  = d;
        m_n       = 1;
      end
    end else if (s) begin
      push_exp(1'b1, m_ch);
      m_buf[0] = d;
      m_n      = 1;
    end else begin
      m_buf[m_n] = d;
      m_n++;
      if (m_n == FLen) begin
        m_recv = 1'b0;
        m_n    = 0;
        ok     = 1'b1;
        par    = '0;
        for (int k = 0; k < int'(N); k++) par = par ^ m_buf[k];
`ifdef TDM_PARITY_EN
        ok = (par == m_buf[N]);
`endif
        if (ok) begin
          for (int k = 0; k < int'(N); k++) m_ch[k*W +: W] = m_buf[k];
          push_exp(1'b0, m_ch);
        end else begin
          push_exp(1'b1, m_ch);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      sof       = 1'b0;
      check("in_frame", {63'd0, in_frame}, {63'd0, m_recv});
    end
  endtask

  // Full frame with correct parity slot when enabled; optional gap after slot 1.
  task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] d, input int gap);
    send(a, 1'b1);
    send(b, 1'b0);
    if (gap > 0) idle(gap);
    send(c, 1'b0);
    send(d, 1'b0);
`ifdef TDM_PARITY_EN
    send(a ^ b ^ c ^ d, 1'b0);
`endif
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (frame_valid || frame_err)) begin
      check("pulse_excl", {63'd0, frame_valid & frame_err}, 64'd0);
      check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("kind_err", {63'd0, frame_err}, {63'd0, e.is_err});
        check("ch_data", {32'd0, ch_data}, {32'd0, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sof       = 1'b0;
    #3;
    check("rst_ch_data", {32'd0, ch_data}, 64'd0);
    check("rst_fv", {63'd0, frame_valid}, 64'd0);
    check("rst_fe", {63'd0, frame_err}, 64'd0);
    check("rst_in_frame", {63'd0, in_frame}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain consecutive frame
    frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    idle(3);
    // Same frame with a 3-cycle gap
    frame(8'h11, 8'h22, 8'h33, 8'h44, 3);
    idle(2);
    // Stray samples in hunt, then a frame
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    frame(8'h01, 8'h02, 8'h03, 8'h04, 0);
    idle(2);
    // Early sof
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    frame(8'h10, 8'h20, 8'h30, 8'h40, 0);
    idle(2);
    // Reset mid-frame between edges
    send(8'h55, 1'b1);
    send(8'h66, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_recv = 1'b0;
    m_n    = 0;
    m_ch   = '0;
    check("mid_rst_ch_data", {32'd0, ch_data}, 64'd0);
    check("mid_rst_fv", {63'd0, frame_valid}, 64'd0);
    check("mid_rst_fe", {63'd0, frame_err}, 64'd0);
    check("mid_rst_in_frame", {63'd0, in_frame}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 0);
    // Back-to-back frames with no dead cycle
    frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 0);
    frame(8'hFF, 8'h00, 8'h80, 8'h01, 0);
    idle(2);
    // Random frames
    for (int i = 0; i < 6; i++) begin
      frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end
    idle(2);
`ifdef TDM_PARITY_EN
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h04, 1'b0);
    send(8'h08, 1'b0);
    send(8'h0F, 1'b0);
    idle(2);
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h04, 1'b0);
    send(8'h08, 1'b0);
    send(8'h0E, 1'b0);
    idle(2);
    // Early sof on the parity slot
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    frame(8'h21, 8'h43, 8'h65, 8'h87, 0);
    idle(2);
`endif
    idle(3);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
